// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus: in-order word requests (valid/ready) and unthrottled responses.
interface instruction_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  reqValid;
  logic [DATA_WIDTH-1:0] reqAddr;
  logic                  reqReady;
  logic                  rspValid;
  logic [DATA_WIDTH-1:0] rspData;

  modport master (
    output reqValid,
    output reqAddr,
    input  reqReady,
    input  rspValid,
    input  rspData
  );

  modport slave (
    input  reqValid,
    input  reqAddr,
    output reqReady,
    output rspValid,
    output rspData
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC generation, in-order imem requests, a prefetch queue of {pc, inst}
// and the IF/ID register, with redirect support that discards stale in-flight responses.
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  instruction_fetch_if.master   imem,
  output logic [DATA_WIDTH-1:0] o_if_inst,
  output logic [DATA_WIDTH-1:0] o_if_pc,
  output logic                  o_if_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h00000013);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [CNT_W-1:0]      fifoCount_q, fifoCount_d;
  logic [PTR_W-1:0]      fifoWr_q, fifoWr_d;
  logic [PTR_W-1:0]      fifoRd_q, fifoRd_d;
  logic [PTR_W-1:0]      tagWr_q, tagWr_d;
  logic [PTR_W-1:0]      tagRd_q, tagRd_d;
  logic [DATA_WIDTH-1:0] fifoPc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] fifoInst_q [DEPTH];
  logic [DATA_WIDTH-1:0] tagPc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] ifInst_q, ifInst_d;
  logic [DATA_WIDTH-1:0] ifPc_q, ifPc_d;
  logic                  ifValid_q, ifValid_d;

  logic [CNT_W:0] occupancy;
  logic           reqValid;
  logic           reqFire;
  logic           rspTake;
  logic           rspDrop;
  logic           fifoPush;
  logic           fifoPop;

  // Every request reserves a queue slot until its instruction leaves, so the queue never overflows.
  always_comb begin
    occupancy = {1'b0, outstanding_q} + {1'b0, fifoCount_q};
    reqValid  = !rst && !i_redirect && (occupancy < {1'b0, DEPTH_C});
    reqFire   = reqValid && imem.reqReady;
    rspTake   = imem.rspValid && (outstanding_q != '0);
    rspDrop   = rspTake && (i_redirect || (drop_q != '0));
    fifoPush  = rspTake && !rspDrop;
    fifoPop   = clk_en && !i_redirect && (fifoCount_q != '0);
  end

  assign imem.reqValid = reqValid;
  assign imem.reqAddr  = fpc_q;

  always_comb begin
    fpc_d         = fpc_q;
    outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(rspTake);
    drop_d        = drop_q;
    fifoCount_d   = fifoCount_q + CNT_W'(fifoPush) - CNT_W'(fifoPop);
    fifoWr_d      = fifoWr_q;
    fifoRd_d      = fifoRd_q;
    tagWr_d       = tagWr_q;
    tagRd_d       = tagRd_q;
    ifInst_d      = ifInst_q;
    ifPc_d        = ifPc_q;
    ifValid_d     = ifValid_q;

    if (reqFire) begin
      fpc_d   = fpc_q + PC_STEP;
      tagWr_d = tagWr_q + PTR_W'(1);
    end
    if (rspTake) begin
      tagRd_d = tagRd_q + PTR_W'(1);
    end
    if (rspTake && !i_redirect && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
    if (fifoPush) begin
      fifoWr_d = fifoWr_q + PTR_W'(1);
    end
    if (fifoPop) begin
      fifoRd_d = fifoRd_q + PTR_W'(1);
    end

    if (clk_en && !i_redirect) begin
      if (fifoCount_q != '0) begin
        ifInst_d  = fifoInst_q[fifoRd_q];
        ifPc_d    = fifoPc_q[fifoRd_q];
        ifValid_d = 1'b1;
      end else begin
        ifInst_d  = NOP_INST;
        ifValid_d = 1'b0;
      end
    end

    // Tags of stale requests stay queued; they are retired one by one as their responses are dropped.
    if (i_redirect) begin
      fpc_d       = i_redirect_pc;
      drop_d      = outstanding_q - CNT_W'(rspTake);
      fifoCount_d = '0;
      fifoRd_d    = fifoWr_q;
      ifInst_d    = NOP_INST;
      ifValid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      fifoCount_q   <= '0;
      fifoWr_q      <= '0;
      fifoRd_q      <= '0;
      tagWr_q       <= '0;
      tagRd_q       <= '0;
      ifInst_q      <= NOP_INST;
      ifPc_q        <= '0;
      ifValid_q     <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifoCount_q   <= fifoCount_d;
      fifoWr_q      <= fifoWr_d;
      fifoRd_q      <= fifoRd_d;
      tagWr_q       <= tagWr_d;
      tagRd_q       <= tagRd_d;
      ifInst_q      <= ifInst_d;
      ifPc_q        <= ifPc_d;
      ifValid_q     <= ifValid_d;
    end
  end

  // Storage arrays need no reset: the counters and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (fifoPush) begin
      fifoPc_q[fifoWr_q]   <= tagPc_q[tagRd_q];
      fifoInst_q[fifoWr_q] <= imem.rspData;
    end
    if (reqFire) begin
      tagPc_q[tagWr_q] <= fpc_q;
    end
  end

  assign o_if_inst  = ifInst_q;
  assign o_if_pc    = ifPc_q;
  assign o_if_valid = ifValid_q;

  assert property (@(posedge clk) disable iff (rst)
    !(fifoPush && !fifoPop && (fifoCount_q == DEPTH_C)));
  assert property (@(posedge clk) disable iff (rst)
    occupancy <= {1'b0, DEPTH_C});

endmodule
